// File: rtl/s_dadda_mac4_acc.sv
// rtl/s_dadda_mac4_acc.sv - sequential dot-product accumulator behind the 4x4 signed Dadda multiplier
//
// Purpose:
//   Sums LEN consecutive signed products from the multiplier into one signed
//   result. Each result carries a flag that is set if any partial sum in that
//   block overflowed. The accumulator wraps modulo 2^ACC_W.
//
// Parameters:
//   PROD_W  product width (signed)
//   ACC_W   accumulator/result width (signed), ACC_W >= PROD_W
//   LEN     products per result, LEN >= 1
//
// Ports:
//   clk         in   1       clock, rising edge
//   rst_n       in   1       asynchronous active-low reset
//   clear       in   1       synchronous abort of the current block
//   prod_valid  in   1       product available
//   prod_ready  out  1       product accepted this cycle
//   prod_data   in   PROD_W  signed product
//   acc_valid   out  1       result available
//   acc_ready   in   1       consumer takes the result this cycle
//   acc_data    out  ACC_W   signed dot-product result
//   acc_ovf     out  1       signed overflow occurred in this result's sum

module s_dadda_mac4_acc #(
  parameter int PROD_W = 8,
  parameter int ACC_W  = 16,
  parameter int LEN    = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              prod_valid,
  output logic              prod_ready,
  input  logic [PROD_W-1:0] prod_data,
  output logic              acc_valid,
  input  logic              acc_ready,
  output logic [ACC_W-1:0]  acc_data,
  output logic              acc_ovf
);

  localparam int CNT_W = $clog2(LEN + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LEN - 1);

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic [ACC_W-1:0]   data_q, data_d;
  logic               oflag_q, oflag_d;
  logic               valid_q, valid_d;

  // Holds prod_ready low for the whole reset period and for the first edge
  // after release, since state alone decodes to ACCUM during reset.
  logic               run_q;

  logic [ACC_W-1:0]   prod_sext;
  logic [ACC_W-1:0]   sum;
  logic               step_ovf;
  logic               ovf_next;
  logic               take;

  // Size cast of a signed operand sign-extends; this stays legal when
  // ACC_W == PROD_W, where a zero-width replication would not be.
  assign prod_sext = ACC_W'($signed(prod_data));
  assign sum       = acc_q + prod_sext;

  // Two's-complement overflow: operands agree in sign, result disagrees.
  assign step_ovf  = (acc_q[ACC_W-1] == prod_sext[ACC_W-1]) &&
                     (sum[ACC_W-1] != acc_q[ACC_W-1]);
  assign ovf_next  = ovf_q | step_ovf;

  // Decoded from registered state only; clear blocks the handshake so that a
  // product offered in the abort cycle is not silently lost.
  assign prod_ready = run_q && (state_q == ACCUM) && !clear;
  assign take       = prod_valid && prod_ready;

  assign acc_valid = valid_q;
  assign acc_data  = data_q;
  assign acc_ovf   = oflag_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ACCUM;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      data_q  <= '0;
      oflag_q <= 1'b0;
      valid_q <= 1'b0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      data_q  <= data_d;
      oflag_q <= oflag_d;
      valid_q <= valid_d;
      run_q   <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    data_d  = data_q;
    oflag_d = oflag_q;
    valid_d = valid_q;

    if (clear) begin
      // acc_data/acc_ovf keep the last delivered result.
      state_d = ACCUM;
      acc_d   = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
      valid_d = 1'b0;
    end else begin
      unique case (state_q)
        ACCUM: begin
          if (take) begin
            if (cnt_q == CNT_LAST) begin
              data_d  = sum;
              oflag_d = ovf_next;
              valid_d = 1'b1;
              state_d = HOLD;
            end else begin
              acc_d = sum;
              cnt_d = cnt_q + CNT_W'(1);
              ovf_d = ovf_next;
            end
          end
        end
        HOLD: begin
          // Running sum is zeroed on hand-off, so the next block starts clean
          // one cycle later (the hand-off cycle itself has prod_ready low).
          if (acc_ready) begin
            valid_d = 1'b0;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
            state_d = ACCUM;
          end
        end
        default: begin
          state_d = ACCUM;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_s_dadda_mac4_acc.sv
// tb/tb_s_dadda_mac4_acc.sv - directed and model-checked bench for s_dadda_mac4_acc
module tb_s_dadda_mac4_acc;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, clear, prod_valid, acc_ready;
  logic [7:0]  prod_data;
  logic        prod_ready, acc_valid, acc_ovf;
  logic [15:0] acc_data;
  logic        prod_ready8, acc_valid8, acc_ovf8;
  logic [7:0]  acc_data8;
  logic        p1_valid, a1_ready, p1_ready, a1_valid, a1_ovf;
  logic [7:0]  p1_data;
  logic [15:0] a1_data;

  int n_cmp = 0;
  int n_bad = 0;

  s_dadda_mac4_acc #(.PROD_W(8), .ACC_W(16), .LEN(4)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .prod_valid(prod_valid), .prod_ready(prod_ready), .prod_data(prod_data),
    .acc_valid(acc_valid), .acc_ready(acc_ready), .acc_data(acc_data), .acc_ovf(acc_ovf)
  );

  s_dadda_mac4_acc #(.PROD_W(8), .ACC_W(8), .LEN(4)) dut8 (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .prod_valid(prod_valid), .prod_ready(prod_ready8), .prod_data(prod_data),
    .acc_valid(acc_valid8), .acc_ready(acc_ready), .acc_data(acc_data8), .acc_ovf(acc_ovf8)
  );

  s_dadda_mac4_acc #(.PROD_W(8), .ACC_W(16), .LEN(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .prod_valid(p1_valid), .prod_ready(p1_ready), .prod_data(p1_data),
    .acc_valid(a1_valid), .acc_ready(a1_ready), .acc_data(a1_data), .acc_ovf(a1_ovf)
  );

  // Offers one product on the shared LEN=4 stream; returns just after the
  // handshake edge with prod_valid still high so calls chain back-to-back.
  task automatic send(input logic [7:0] v);
    int t;
    t = 0;
    prod_valid = 1'b1;
    prod_data  = v;
    while (1) begin
      @(negedge clk);
      if (prod_ready === 1'b1) break;
      t++;
      if (t > 50) begin
        n_cmp++; n_bad++;
        $display("FAIL send_timeout prod_ready=%b required 1", prod_ready);
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic recv(input logic [15:0] e16, input logic eo16,
                      input logic [7:0] e8, input logic eo8, input string nm);
    int t;
    t = 0;
    prod_valid = 1'b0;
    while (acc_valid !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    n_cmp++; if (acc_valid !== 1'b1) begin n_bad++; $display("FAIL %s_valid got=%b exp=1", nm, acc_valid); end
    n_cmp++; if (acc_data !== e16) begin n_bad++; $display("FAIL %s_data got=%h exp=%h", nm, acc_data, e16); end
    n_cmp++; if (acc_ovf !== eo16) begin n_bad++; $display("FAIL %s_ovf got=%b exp=%b", nm, acc_ovf, eo16); end
    n_cmp++; if (acc_valid8 !== 1'b1) begin n_bad++; $display("FAIL %s_valid8 got=%b exp=1", nm, acc_valid8); end
    n_cmp++; if (acc_data8 !== e8) begin n_bad++; $display("FAIL %s_data8 got=%h exp=%h", nm, acc_data8, e8); end
    n_cmp++; if (acc_ovf8 !== eo8) begin n_bad++; $display("FAIL %s_ovf8 got=%b exp=%b", nm, acc_ovf8, eo8); end
    @(negedge clk);
    n_cmp++; if (prod_ready !== 1'b0) begin n_bad++; $display("FAIL %s_hold_ready got=%b exp=0", nm, prod_ready); end
    acc_ready = 1'b1;
    @(posedge clk); #1;
    acc_ready = 1'b0;
    n_cmp++; if (acc_valid !== 1'b0) begin n_bad++; $display("FAIL %s_drop_valid got=%b exp=0", nm, acc_valid); end
    n_cmp++; if (prod_ready !== 1'b1) begin n_bad++; $display("FAIL %s_bubble_ready got=%b exp=1", nm, prod_ready); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clear = 1'b0; prod_valid = 1'b0; prod_data = '0; acc_ready = 1'b0;
    p1_valid = 1'b0; p1_data = '0; a1_ready = 1'b0;
    #1;
    n_cmp++; if (prod_ready !== 1'b0) begin n_bad++; $display("FAIL rst_ready got=%b exp=0", prod_ready); end
    n_cmp++; if (acc_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid got=%b exp=0", acc_valid); end
    n_cmp++; if (acc_data !== 16'h0) begin n_bad++; $display("FAIL rst_data got=%h exp=0000", acc_data); end
    n_cmp++; if (acc_ovf !== 1'b0) begin n_bad++; $display("FAIL rst_ovf got=%b exp=0", acc_ovf); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (prod_ready !== 1'b0) begin n_bad++; $display("FAIL rel_ready_early got=%b exp=0", prod_ready); end
    @(negedge clk);
    n_cmp++; if (prod_ready !== 1'b1) begin n_bad++; $display("FAIL rel_ready got=%b exp=1", prod_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    send(8'd64); send(8'd64); send(8'd64);
    n_cmp++; if (acc_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_early_valid got=%b exp=0", acc_valid); end
    send(8'd64);
    n_cmp++; if (acc_valid !== 1'b1) begin n_bad++; $display("FAIL b2b_latency got=%b exp=1", acc_valid); end
    recv(16'h0100, 1'b0, 8'h00, 1'b1, "b2b");
  endtask

  task automatic test_signed();
    send(8'hC8); send(8'd10); send(8'd3); send(8'hFF);
    recv(16'hFFD4, 1'b0, 8'hD4, 1'b0, "signed");
  endtask

  task automatic test_hold();
    send(8'd1); send(8'd2); send(8'd3); send(8'd4);
    prod_valid = 1'b1; prod_data = 8'd99;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_cmp++; if (acc_valid !== 1'b1) begin n_bad++; $display("FAIL hold_valid got=%b exp=1", acc_valid); end
      n_cmp++; if (prod_ready !== 1'b0) begin n_bad++; $display("FAIL hold_ready got=%b exp=0", prod_ready); end
      n_cmp++; if (acc_data !== 16'd10) begin n_bad++; $display("FAIL hold_data got=%h exp=000a", acc_data); end
    end
    recv(16'd10, 1'b0, 8'd10, 1'b0, "hold");
    send(8'd5); send(8'd5); send(8'd5); send(8'd5);
    recv(16'd20, 1'b0, 8'd20, 1'b0, "after_hold");
  endtask

  task automatic test_overflow();
    send(8'd64); send(8'd64); send(8'd0); send(8'd0);
    recv(16'h0080, 1'b0, 8'h80, 1'b1, "ovf");
    send(8'd1); send(8'd1); send(8'd1); send(8'd1);
    recv(16'd4, 1'b0, 8'd4, 1'b0, "ovf_cleared");
  endtask

  task automatic test_clear();
    send(8'd7); send(8'd7);
    clear = 1'b1; prod_valid = 1'b1; prod_data = 8'd7;
    @(negedge clk);
    n_cmp++; if (prod_ready !== 1'b0) begin n_bad++; $display("FAIL clear_ready got=%b exp=0", prod_ready); end
    @(posedge clk); #1;
    clear = 1'b0;
    send(8'd1); send(8'd2); send(8'd3); send(8'd4);
    recv(16'd10, 1'b0, 8'd10, 1'b0, "clear");
  endtask

  task automatic test_reset_mid();
    send(8'd1); send(8'd2);
    prod_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (prod_ready !== 1'b0) begin n_bad++; $display("FAIL midrst_ready got=%b exp=0", prod_ready); end
    @(posedge clk); #1 rst_n = 1'b1;
    send(8'd64); send(8'd64); send(8'd0); send(8'd0);
    prod_valid = 1'b0;
    n_cmp++; if (acc_ovf8 !== 1'b1) begin n_bad++; $display("FAIL holdrst_pre_ovf8 got=%b exp=1", acc_ovf8); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (acc_valid !== 1'b0) begin n_bad++; $display("FAIL holdrst_valid got=%b exp=0", acc_valid); end
    n_cmp++; if (acc_data !== 16'h0) begin n_bad++; $display("FAIL holdrst_data got=%h exp=0000", acc_data); end
    n_cmp++; if (acc_data8 !== 8'h0) begin n_bad++; $display("FAIL holdrst_data8 got=%h exp=00", acc_data8); end
    n_cmp++; if (acc_ovf8 !== 1'b0) begin n_bad++; $display("FAIL holdrst_ovf8 got=%b exp=0", acc_ovf8); end
    @(posedge clk); #1 rst_n = 1'b1;
    send(8'd3); send(8'd3); send(8'd3); send(8'd3);
    recv(16'd12, 1'b0, 8'd12, 1'b0, "after_rst");
  endtask

  task automatic test_len1();
    logic [7:0]  vin [3];
    logic [15:0] vex [3];
    int t;
    vin[0] = 8'd5;  vex[0] = 16'h0005;
    vin[1] = 8'hFD; vex[1] = 16'hFFFD;
    vin[2] = 8'h80; vex[2] = 16'hFF80;
    for (int i = 0; i < 3; i++) begin
      p1_valid = 1'b1; p1_data = vin[i]; t = 0;
      @(negedge clk);
      while (p1_ready !== 1'b1 && t < 50) begin @(negedge clk); t++; end
      @(posedge clk); #1;
      p1_valid = 1'b0;
      n_cmp++; if (a1_valid !== 1'b1) begin n_bad++; $display("FAIL len1_valid[%0d] got=%b exp=1", i, a1_valid); end
      n_cmp++; if (a1_data !== vex[i]) begin n_bad++; $display("FAIL len1_data[%0d] got=%h exp=%h", i, a1_data, vex[i]); end
      n_cmp++; if (a1_ovf !== 1'b0) begin n_bad++; $display("FAIL len1_ovf[%0d] got=%b exp=0", i, a1_ovf); end
      @(negedge clk); a1_ready = 1'b1;
      @(posedge clk); #1 a1_ready = 1'b0;
      n_cmp++; if (a1_valid !== 1'b0) begin n_bad++; $display("FAIL len1_drop[%0d] got=%b exp=0", i, a1_valid); end
    end
  endtask

  // Reference: integer sums; 8-bit overflow judged by range of each true partial sum.
  task automatic test_random();
    logic [7:0] p, w8;
    int s, a8, pi, tt;
    logic o8;
    for (int b = 0; b < 1000; b++) begin
      s = 0; a8 = 0; o8 = 1'b0;
      for (int k = 0; k < 4; k++) begin
        p  = 8'($urandom_range(0, 255));
        pi = int'($signed(p));
        s  = s + pi;
        tt = a8 + pi;
        if (tt > 127 || tt < -128) o8 = 1'b1;
        w8 = tt[7:0];
        a8 = int'($signed(w8));
        send(p);
      end
      recv(16'(s), 1'b0, w8, o8, "rand");
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_signed();
    test_hold();
    test_overflow();
    test_clear();
    test_reset_mid();
    test_len1();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
